crypto_xperm_iter: RTL and testbench

- Parametrised, iterative successor of the combinational crossbar-permutation unit. Implements Zbkx xperm4/xperm8 for any legal XLEN.
- Processes CHUNK_BITS of rs2 per cycle under a valid/ready handshake, with flush and a transaction-ID passthrough.
- Sits in the crypto functional unit beside the other crypto datapaths. Its multi-cycle result path keeps the XLEN-wide barrel lookup off the critical path.

---
 rtl/crypto_xperm_iter.sv | 134 +++++++++++++
 tb/tb_crypto_xperm_iter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_xperm_iter.sv
// Iterative Zbkx crossbar permutation (xperm4 / xperm8).
// Each BUSY cycle permutes one CHUNK_BITS slice of the captured index vector
// against the full captured lookup table. The result is held in DONE until
// the consumer takes it.
module crypto_xperm_iter #(
    parameter int XLEN          = 64,
    parameter int CHUNK_BITS    = 16,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     op_i,
    input  logic [XLEN-1:0]          rs1_i,
    input  logic [XLEN-1:0]          rs2_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int N     = XLEN / CHUNK_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     accept;
    logic                     chunk_last;
    logic [CNT_W-1:0]         cnt_q;
    logic [XLEN-1:0]          rs1_q;
    logic [XLEN-1:0]          rs2_q;
    logic                     op_q;
    logic [XLEN-1:0]          result_q;
    logic [TRANS_ID_BITS-1:0] tid_q;
    logic [CHUNK_BITS-1:0]    chunk_idx;
    logic [CHUNK_BITS-1:0]    chunk_res;
    logic [XLEN-1:0]          chunk_ext;

    // Byte lookup; indices past the table return zero rather than wrapping.
    function automatic logic [7:0] lut8(input logic [XLEN-1:0] lut, input logic [7:0] idx);
        if (int'(idx) >= XLEN / 8) return 8'h00;
        return lut[int'(idx) * 8 +: 8];
    endfunction

    // Nibble lookup; indices past the table return zero rather than wrapping.
    function automatic logic [3:0] lut4(input logic [XLEN-1:0] lut, input logic [3:0] idx);
        if (int'(idx) >= XLEN / 4) return 4'h0;
        return lut[int'(idx) * 4 +: 4];
    endfunction

    // Permute the current slice of rs2 against the whole captured rs1.
    always_comb begin
        chunk_idx = rs2_q[int'(cnt_q) * CHUNK_BITS +: CHUNK_BITS];
        chunk_res = '0;
        if (op_q) begin
            for (int e = 0; e < CHUNK_BITS / 8; e++) begin
                chunk_res[e*8 +: 8] = lut8(rs1_q, chunk_idx[e*8 +: 8]);
            end
        end else begin
            for (int e = 0; e < CHUNK_BITS / 4; e++) begin
                chunk_res[e*4 +: 4] = lut4(rs1_q, chunk_idx[e*4 +: 4]);
            end
        end
        chunk_ext = '0;
        chunk_ext[CHUNK_BITS-1:0] = chunk_res;
    end

    // Next state and handshake outputs; flush overrides any acceptance.
    always_comb begin
        state_d    = state_q;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        chunk_last = (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: ready_o = 1'b1;
            BUSY: if (chunk_last) state_d = DONE;
            DONE: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = valid_i & ready_o & ~flush_i;
        if (accept) state_d = BUSY;
        if (flush_i) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Chunk counter, accumulated result and returned tag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            result_q <= '0;
            tid_q    <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            result_q <= '0;
            tid_q    <= trans_id_i;
        end else if (state_q == BUSY) begin
            result_q <= result_q | (chunk_ext << (int'(cnt_q) * CHUNK_BITS));
            cnt_q    <= chunk_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Operand capture; inputs are ignored once the request is taken.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
            op_q  <= op_i;
        end
    end

    assign result_o   = result_q;
    assign trans_id_o = tid_q;

endmodule

// File: tb/tb_crypto_xperm_iter.sv
// Bench for crypto_xperm_iter: one XLEN=64/CHUNK=16 instance and one
// XLEN=32/CHUNK=16 instance, directed cases plus randomized operations
// against a specification-level permutation model.
module tb_crypto_xperm_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        flush64, valid64, rdy64, op64, vo64, ri64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  tid64, tido64;

    logic        flush32, valid32, rdy32, op32, vo32, ri32;
    logic [31:0] a32, b32, res32;
    logic [2:0]  tid32, tido32;

    crypto_xperm_iter #(.XLEN(64), .CHUNK_BITS(16), .TRANS_ID_BITS(3)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush64), .valid_i(valid64),
        .ready_o(rdy64), .op_i(op64), .rs1_i(a64), .rs2_i(b64),
        .trans_id_i(tid64), .valid_o(vo64), .ready_i(ri64),
        .result_o(res64), .trans_id_o(tido64)
    );

    crypto_xperm_iter #(.XLEN(32), .CHUNK_BITS(16), .TRANS_ID_BITS(3)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush32), .valid_i(valid32),
        .ready_o(rdy32), .op_i(op32), .rs1_i(a32), .rs2_i(b32),
        .trans_id_i(tid32), .valid_o(vo32), .ready_i(ri32),
        .result_o(res32), .trans_id_o(tido32)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Element-wise definition: each W-bit index selects a W-bit table entry,
    // out-of-table indices give zero.
    function automatic logic [63:0] ref_xperm(input bit op8, input logic [63:0] lut,
                                              input logic [63:0] idxv, input int xlen);
        int              w;
        logic [63:0]     r;
        logic [63:0]     m;
        longint unsigned idx;
        w = op8 ? 8 : 4;
        m = (64'd1 << w) - 64'd1;
        r = '0;
        for (int i = 0; i < xlen / w; i++) begin
            idx = (idxv >> (i * w)) & m;
            if (idx * w < xlen) r |= ((lut >> (idx * w)) & m) << (i * w);
        end
        return r;
    endfunction

    function automatic logic [63:0] o_res(input bit sel);
        return sel ? {32'h0, res32} : res64;
    endfunction
    function automatic logic o_vld(input bit sel);
        return sel ? vo32 : vo64;
    endfunction
    function automatic logic o_rdy(input bit sel);
        return sel ? rdy32 : rdy64;
    endfunction
    function automatic logic [2:0] o_tid(input bit sel);
        return sel ? tido32 : tido64;
    endfunction

    task automatic drive_in(input bit sel, input bit op, input logic [63:0] a,
                            input logic [63:0] b, input logic [2:0] tid, input bit v);
        if (sel) begin
            valid32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; tid32 = tid;
        end else begin
            valid64 = v; op64 = op; a64 = a; b64 = b; tid64 = tid;
        end
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic issue(input bit sel, input bit op, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] tid);
        check("issue_ready", 64'(o_rdy(sel)), 64'd1);
        drive_in(sel, op, a, b, tid, 1'b1);
        @(posedge clk); #1;
        drive_in(sel, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 3'($urandom), 1'b0);
    endtask

    task automatic wait_done(input bit sel, input logic [63:0] exp, input logic [2:0] tid);
        int lat;
        lat = 0;
        while (o_vld(sel) !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), sel ? 64'd2 : 64'd4);
        check("result", o_res(sel), exp);
        check("trans_id", 64'(o_tid(sel)), 64'(tid));
    endtask

    task automatic run_op(input bit sel, input bit op, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] tid, input logic [63:0] exp);
        issue(sel, op, a, b, tid);
        wait_done(sel, exp, tid);
        @(posedge clk); #1;
        check("consumed", 64'(o_vld(sel)), 64'd0);
    endtask

    task automatic count_valid(input bit sel, input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (o_vld(sel) === 1'b1) seen++;
        end
    endtask

    initial begin
        bit          sel, op;
        logic [63:0] a, b, e, hold_res;
        logic [2:0]  t;
        int          seen;

        rst_n = 1'b0;
        flush64 = 1'b0; flush32 = 1'b0; ri64 = 1'b1; ri32 = 1'b1;
        drive_in(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive_in(1'b1, 1'b0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", 64'(o_vld(s[0])), 64'd0);
            check("rst_ready", 64'(o_rdy(s[0])), 64'd1);
            check("rst_result", o_res(s[0]), 64'd0);
            check("rst_tid", 64'(o_tid(s[0])), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(1'b0, 1'b0, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 3'd5, 64'h0123456789ABCDEF);
        run_op(1'b0, 1'b1, 64'h8877665544332211, 64'h0000000000000007, 3'd2, 64'h1111111111111188);
        run_op(1'b0, 1'b1, 64'h8877665544332211, 64'hFFFFFFFFFFFFFF08, 3'd3, 64'h0);
        run_op(1'b1, 1'b1, 64'h44332211, 64'h04030201, 3'd6, 64'h00443322);
        run_op(1'b1, 1'b0, 64'h76543210, 64'hFEDC3210, 3'd1, 64'h00003210);

        // Randomized operations on both widths
        for (int i = 0; i < 30; i++) begin
            sel = i[0];
            op  = 1'($urandom);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) b &= 64'h0707070707070707;
            if (sel) begin
                a &= 64'hFFFF_FFFF;
                b &= 64'hFFFF_FFFF;
            end
            t = 3'($urandom);
            e = ref_xperm(op, a, b, sel ? 32 : 64);
            run_op(sel, op, a, b, t, e);
        end

        // Backpressure in DONE, then same-cycle acceptance of the next request
        a = 64'h0F1E2D3C4B5A6978; b = 64'h0102030405060700;
        e = ref_xperm(1'b1, a, b, 64);
        ri64 = 1'b0; #1;
        issue(1'b0, 1'b1, a, b, 3'd4);
        wait_done(1'b0, e, 3'd4);
        hold_res = res64;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(vo64), 64'd1);
            check("bp_ready", 64'(rdy64), 64'd0);
            check("bp_result", res64, hold_res);
            check("bp_tid", 64'(tido64), 64'd4);
        end
        ri64 = 1'b1; #1;
        a = 64'hFEDCBA9876543210; b = 64'h13579BDF02468ACE;
        issue(1'b0, 1'b0, a, b, 3'd7);
        check("b2b_busy_valid", 64'(vo64), 64'd0);
        wait_done(1'b0, 64'h13579BDF02468ACE, 3'd7);
        @(posedge clk); #1;

        // Flush in BUSY at counter 2
        issue(1'b0, 1'b1, 64'h8877665544332211, 64'h0001020304050607, 3'd3);
        repeat (2) @(posedge clk);
        #1;
        flush64 = 1'b1;
        @(posedge clk); #1;
        flush64 = 1'b0;
        check("flush_busy_valid", 64'(vo64), 64'd0);
        check("flush_busy_ready", 64'(rdy64), 64'd1);
        count_valid(1'b0, 8, seen);
        check("flush_busy_no_result", 64'(seen), 64'd0);
        run_op(1'b0, 1'b1, 64'h8877665544332211, 64'h0001020304050607, 3'd2, 64'h1122334455667788);

        // Flush wins over a simultaneous request
        drive_in(1'b0, 1'b0, 64'hFEDCBA9876543210, 64'h1111111111111111, 3'd1, 1'b1);
        flush64 = 1'b1; #1;
        check("flush_accept_ready", 64'(rdy64), 64'd1);
        @(posedge clk); #1;
        flush64 = 1'b0;
        drive_in(1'b0, 1'b0, '0, '0, '0, 1'b0);
        count_valid(1'b0, 8, seen);
        check("flush_accept_dropped", 64'(seen), 64'd0);
        check("flush_accept_idle", 64'(rdy64), 64'd1);

        // Flush in DONE discards the pending result
        ri64 = 1'b0; #1;
        issue(1'b0, 1'b0, 64'hFEDCBA9876543210, 64'hAAAAAAAAAAAAAAAA, 3'd6);
        wait_done(1'b0, 64'hAAAAAAAAAAAAAAAA, 3'd6);
        flush64 = 1'b1;
        @(posedge clk); #1;
        flush64 = 1'b0;
        check("flush_done_valid", 64'(vo64), 64'd0);
        check("flush_done_ready", 64'(rdy64), 64'd0 + 64'(ri64 == 1'b0));

        // Reset while holding a result in DONE
        issue(1'b0, 1'b1, 64'h8877665544332211, 64'h0706050403020100, 3'd7);
        wait_done(1'b0, 64'h8877665544332211, 3'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_done_valid", 64'(vo64), 64'd0);
        check("rst_done_result", res64, 64'd0);
        check("rst_done_tid", 64'(tido64), 64'd0);
        check("rst_done_ready", 64'(rdy64), 64'd1);
        ri64 = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 1'b1, 64'h8877665544332211, 64'h0000000000000007, 3'd5, 64'h1111111111111188);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
